// File: rtl/cast_pipe.sv
// cast_pipe: two-stage valid/ready pipeline applying BOOL/RANGE/SEXT/REPACK casts over CH lanes.
// Define CAST_PIPE_LOSS_CNT_EN to build the saturating lossy-lane counter behind loss_cnt.
module cast_pipe #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 15,
  parameter int CH    = 2,
  parameter int SPLIT = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            in_mode,
  input  logic [CH*IN_W-1:0]    in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CH*OUT_W-1:0]   out_data,
  output logic [CH-1:0]         out_lossy,
  input  logic                  loss_clr,
  output logic [15:0]           loss_cnt
);

  localparam logic [1:0] MODE_BOOL   = 2'd0;
  localparam logic [1:0] MODE_RANGE  = 2'd1;
  localparam logic [1:0] MODE_SEXT   = 2'd2;
  localparam logic [1:0] MODE_REPACK = 2'd3;

  logic                 s1_valid_q;
  logic [1:0]           s1_mode_q;
  logic [CH*IN_W-1:0]   s1_data_q;
  logic                 out_valid_q;
  logic [CH*OUT_W-1:0]  out_data_q;
  logic [CH-1:0]        out_lossy_q;
  logic [CH*OUT_W-1:0]  res_d;
  logic [CH-1:0]        lossy_d;
  logic                 s2_load_s;
  logic                 s1_load_s;

  // S1 may refill in the same cycle S2 drains, which keeps the pipe at full rate
  assign s2_load_s = !out_valid_q || out_ready;
  assign s1_load_s = !s1_valid_q || s2_load_s;
  assign in_ready  = s1_load_s;

  // Stage 1: capture the raw beat and its mode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_mode_q  <= 2'd0;
      s1_data_q  <= '0;
    end else if (s1_load_s) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_mode_q <= in_mode;
        s1_data_q <= in_data;
      end
    end
  end

  for (genvar g = 0; g < CH; g++) begin : g_lane
    logic [IN_W-1:0]  x_s;
    logic [OUT_W-1:0] r_s;
    logic [OUT_W-1:0] sx_s;
    logic [OUT_W-1:0] rp_s;
    logic [OUT_W-1:0] lane_res_s;
    logic             range_loss_s;
    logic             sext_loss_s;
    logic             lane_loss_s;

    assign x_s = s1_data_q[g*IN_W +: IN_W];

    if (IN_W <= OUT_W) begin : g_ext
      assign r_s          = OUT_W'(x_s);
      assign sx_s         = OUT_W'($signed(x_s));
      assign range_loss_s = 1'b0;
      assign sext_loss_s  = 1'b0;
    end else begin : g_trunc
      // A truncated signed value is exact only if every dropped bit copies the new sign bit
      assign r_s          = x_s[OUT_W-1:0];
      assign sx_s         = x_s[OUT_W-1:0];
      assign range_loss_s = |x_s[IN_W-1:OUT_W];
      assign sext_loss_s  = (x_s[IN_W-1:OUT_W] != {(IN_W-OUT_W){x_s[OUT_W-1]}});
    end

    if (SPLIT >= 1 && SPLIT < OUT_W) begin : g_swap
      assign rp_s = {r_s[SPLIT-1:0], r_s[OUT_W-1:SPLIT]};
    end else begin : g_noswap
      assign rp_s = r_s;
    end

    // Per-lane mode select
    always_comb begin
      lane_res_s  = '0;
      lane_loss_s = 1'b0;
      case (s1_mode_q)
        MODE_BOOL: begin
          lane_res_s  = OUT_W'(|x_s);
          lane_loss_s = 1'b0;
        end
        MODE_RANGE: begin
          lane_res_s  = r_s;
          lane_loss_s = range_loss_s;
        end
        MODE_SEXT: begin
          lane_res_s  = sx_s;
          lane_loss_s = sext_loss_s;
        end
        MODE_REPACK: begin
          lane_res_s  = rp_s;
          lane_loss_s = range_loss_s;
        end
        default: begin
          lane_res_s  = '0;
          lane_loss_s = 1'b0;
        end
      endcase
    end

    assign res_d[g*OUT_W +: OUT_W] = lane_res_s;
    assign lossy_d[g]              = lane_loss_s;
  end

  // Stage 2: registered result; held while the consumer stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_lossy_q <= '0;
    end else if (s2_load_s) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        out_data_q  <= res_d;
        out_lossy_q <= lossy_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_lossy = out_lossy_q;

`ifdef CAST_PIPE_LOSS_CNT_EN
  logic [15:0] loss_cnt_q;
  logic [15:0] loss_cnt_d;
  logic [16:0] loss_sum_s;

  function automatic logic [15:0] popcount(input logic [CH-1:0] v);
    logic [15:0] c;
    c = 16'd0;
    for (int i = 0; i < CH; i++) begin
      c = c + 16'(v[i]);
    end
    return c;
  endfunction

  // Clear beats a same-cycle increment; the sum saturates at all-ones
  always_comb begin
    loss_sum_s = {1'b0, loss_cnt_q} + {1'b0, popcount(out_lossy_q)};
    if (loss_clr) begin
      loss_cnt_d = 16'd0;
    end else if (out_valid_q && out_ready) begin
      loss_cnt_d = loss_sum_s[16] ? 16'hFFFF : loss_sum_s[15:0];
    end else begin
      loss_cnt_d = loss_cnt_q;
    end
  end

  // Loss counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      loss_cnt_q <= 16'd0;
    end else begin
      loss_cnt_q <= loss_cnt_d;
    end
  end

  assign loss_cnt = loss_cnt_q;
`else
  logic unused_loss_clr_s;
  assign unused_loss_clr_s = loss_clr;
  assign loss_cnt          = 16'd0;
`endif

endmodule

// File: tb/tb_cast_pipe.sv
// Scoreboard bench for cast_pipe: a default instance and an IN_W=16/OUT_W=8 narrowing instance.
module tb_cast_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_loss_clr;
  logic [1:0]  a_in_mode;
  logic [15:0] a_in_data;
  logic [29:0] a_out_data;
  logic [1:0]  a_out_lossy;
  logic [15:0] a_loss_cnt;
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_loss_clr;
  logic [1:0]  b_in_mode;
  logic [31:0] b_in_data;
  logic [15:0] b_out_data;
  logic [1:0]  b_out_lossy;
  logic [15:0] b_loss_cnt;

  cast_pipe dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_mode(a_in_mode), .in_data(a_in_data), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .out_data(a_out_data), .out_lossy(a_out_lossy),
    .loss_clr(a_loss_clr), .loss_cnt(a_loss_cnt)
  );

  cast_pipe #(.IN_W(16), .OUT_W(8), .CH(2), .SPLIT(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_mode(b_in_mode), .in_data(b_in_data), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_data(b_out_data), .out_lossy(b_out_lossy),
    .loss_clr(b_loss_clr), .loss_cnt(b_loss_cnt)
  );

  logic [63:0] a_q[$];
  logic [63:0] b_q[$];
  int          tests = 0;
  int          fails = 0;
  int          a_acc = 0;
  int          b_acc = 0;
  logic [15:0] a_cnt_m = 16'd0;
  logic [15:0] b_cnt_m = 16'd0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference cast of one lane: returns {lossy, value}
  function automatic logic [32:0] lane_model(input int inw, input int outw, input int split,
                                             input logic [1:0] mode, input logic [31:0] x);
    logic [31:0] mi, mo, r, o, dmask;
    logic        l;
    mi = (32'd1 << inw) - 32'd1;
    mo = (32'd1 << outw) - 32'd1;
    r  = x & mo;
    o  = 32'd0;
    l  = 1'b0;
    case (mode)
      2'd0: o = (x != 32'd0) ? 32'd1 : 32'd0;
      2'd1: begin o = r; l = ((x >> outw) != 32'd0); end
      2'd2: begin
        if (inw <= outw) begin
          o = (((x >> (inw - 1)) & 32'd1) != 32'd0) ? (x | (mo & ~mi)) : x;
        end else begin
          o     = r;
          dmask = (32'd1 << (inw - outw)) - 32'd1;
          l     = ((x >> outw) != ((((r >> (outw - 1)) & 32'd1) != 32'd0) ? dmask : 32'd0));
        end
      end
      default: begin
        o = ((r & ((32'd1 << split) - 32'd1)) << (outw - split)) | (r >> split);
        l = ((x >> outw) != 32'd0);
      end
    endcase
    return {l, o};
  endfunction

  function automatic logic [63:0] exp_beat(input int inw, input int outw, input int split,
                                           input logic [1:0] mode, input logic [63:0] din);
    logic [63:0] res;
    logic [32:0] lm;
    logic [31:0] x;
    res = 64'd0;
    for (int i = 0; i < 2; i++) begin
      x   = 32'(din >> (i * inw)) & ((32'd1 << inw) - 32'd1);
      lm  = lane_model(inw, outw, split, mode, x);
      res = res | (64'(lm[31:0]) << (i * outw)) | (64'(lm[32]) << (2 * outw + i));
    end
    return res;
  endfunction

  function automatic logic [15:0] sat_add(input logic [15:0] c, input logic [1:0] lossy);
    int s;
    s = int'(c) + int'(lossy[0]) + int'(lossy[1]);
    return (s > 65535) ? 16'hFFFF : 16'(s);
  endfunction

  // Sample handshakes just before the rising edge, then return at the falling edge
  task automatic tick();
    logic [63:0] e;
    #4;
    if (!rst_n) begin
      a_cnt_m = 16'd0;
      b_cnt_m = 16'd0;
    end else begin
      if (a_in_valid && a_in_ready) begin
        a_q.push_back(exp_beat(8, 15, 1, a_in_mode, 64'(a_in_data)));
        a_acc++;
      end
      if (b_in_valid && b_in_ready) begin
        b_q.push_back(exp_beat(16, 8, 3, b_in_mode, 64'(b_in_data)));
        b_acc++;
      end
      e = 64'd0;
      if (a_out_valid && a_out_ready) begin
        chk("a_sb_nonempty", 64'(a_q.size() != 0), 64'd1);
        if (a_q.size() != 0) begin
          e = a_q.pop_front();
          chk("a_beat", 64'({a_out_lossy, a_out_data}), e);
        end
      end
`ifdef CAST_PIPE_LOSS_CNT_EN
      if (a_loss_clr) a_cnt_m = 16'd0;
      else if (a_out_valid && a_out_ready) a_cnt_m = sat_add(a_cnt_m, e[31:30]);
`endif
      e = 64'd0;
      if (b_out_valid && b_out_ready) begin
        chk("b_sb_nonempty", 64'(b_q.size() != 0), 64'd1);
        if (b_q.size() != 0) begin
          e = b_q.pop_front();
          chk("b_beat", 64'({b_out_lossy, b_out_data}), e);
        end
      end
`ifdef CAST_PIPE_LOSS_CNT_EN
      if (b_loss_clr) b_cnt_m = 16'd0;
      else if (b_out_valid && b_out_ready) b_cnt_m = sat_add(b_cnt_m, e[17:16]);
`endif
    end
    @(negedge clk);
    chk("a_loss_cnt", 64'(a_loss_cnt), 64'(a_cnt_m));
    chk("b_loss_cnt", 64'(b_loss_cnt), 64'(b_cnt_m));
  endtask

  task automatic drain();
    a_in_valid = 1'b0; b_in_valid = 1'b0;
    a_out_ready = 1'b1; b_out_ready = 1'b1;
    for (int i = 0; i < 50 && (a_q.size() != 0 || b_q.size() != 0); i++) tick();
    chk("drain_a", 64'(a_q.size()), 64'd0);
    chk("drain_b", 64'(b_q.size()), 64'd0);
  endtask

  // One beat on A with latency and explicit value checks
  task automatic beat_a(input string tag, input logic [1:0] mode, input logic [15:0] din,
                        input logic [29:0] ed, input logic [1:0] el);
    a_out_ready = 1'b1;
    chk({tag, "_in_ready"}, 64'(a_in_ready), 64'd1);
    a_in_valid = 1'b1; a_in_mode = mode; a_in_data = din;
    tick();
    a_in_valid = 1'b0;
    chk({tag, "_lat1_valid"}, 64'(a_out_valid), 64'd0);
    tick();
    chk({tag, "_lat2_valid"}, 64'(a_out_valid), 64'd1);
    chk({tag, "_data"}, 64'(a_out_data), 64'(ed));
    chk({tag, "_lossy"}, 64'(a_out_lossy), 64'(el));
    tick();
  endtask

  task automatic beat_b(input string tag, input logic [1:0] mode, input logic [31:0] din,
                        input logic [15:0] ed, input logic [1:0] el);
    b_out_ready = 1'b1;
    b_in_valid = 1'b1; b_in_mode = mode; b_in_data = din;
    tick();
    b_in_valid = 1'b0;
    tick();
    chk({tag, "_valid"}, 64'(b_out_valid), 64'd1);
    chk({tag, "_data"}, 64'(b_out_data), 64'(ed));
    chk({tag, "_lossy"}, 64'(b_out_lossy), 64'(el));
    tick();
  endtask

  initial begin
    logic [15:0] bp_vals[4];
    logic [63:0] e0;
    rst_n = 1'b0;
    a_in_valid = 1'b0; a_in_mode = 2'd0; a_in_data = 16'd0; a_out_ready = 1'b1; a_loss_clr = 1'b0;
    b_in_valid = 1'b0; b_in_mode = 2'd0; b_in_data = 32'd0; b_out_ready = 1'b1; b_loss_clr = 1'b0;
    #2;
    chk("rst_out_valid", 64'(a_out_valid), 64'd0);
    chk("rst_out_data", 64'(a_out_data), 64'd0);
    chk("rst_out_lossy", 64'(a_out_lossy), 64'd0);
    chk("rst_loss_cnt", 64'(a_loss_cnt), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", 64'(a_in_ready), 64'd1);
    @(negedge clk);

    beat_a("a_bool", 2'd0, 16'h0080, {15'h0000, 15'h0001}, 2'b00);
    beat_a("a_range", 2'd1, 16'hA5A5, {15'h00A5, 15'h00A5}, 2'b00);
    beat_a("a_sext", 2'd2, 16'hA5A5, {15'h7FA5, 15'h7FA5}, 2'b00);
    beat_a("a_repack", 2'd3, 16'h0101, {15'h4000, 15'h4000}, 2'b00);
    beat_b("b_range", 2'd1, {16'h0000, 16'h01FF}, {8'h00, 8'hFF}, 2'b01);
    beat_b("b_sext", 2'd2, {16'h0080, 16'hFF80}, {8'h80, 8'h80}, 2'b10);
    beat_b("b_repack", 2'd3, {16'h0100, 16'h0001}, {8'h00, 8'h20}, 2'b10);

    // Back-to-back beats at full rate
    a_acc = 0;
    for (int i = 0; i < 8; i++) begin
      chk("thru_in_ready", 64'(a_in_ready), 64'd1);
      a_in_valid = 1'b1; a_in_mode = 2'(i); a_in_data = 16'($urandom);
      tick();
    end
    chk("thru_accepted", 64'(a_acc), 64'd8);
    drain();

    // Output stalled for 5 cycles while 4 beats are offered
    bp_vals[0] = 16'h1234; bp_vals[1] = 16'h00FF; bp_vals[2] = 16'hBEEF; bp_vals[3] = 16'h7F01;
    e0 = exp_beat(8, 15, 1, 2'd1, 64'(bp_vals[0]));
    a_acc = 0;
    a_out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      a_in_valid = 1'b1; a_in_mode = 2'd1; a_in_data = bp_vals[a_acc];
      tick();
      if (a_out_valid) chk("stall_hold", 64'({a_out_lossy, a_out_data}), e0);
    end
    chk("stall_accepted", 64'(a_acc), 64'd2);
    chk("stall_in_ready", 64'(a_in_ready), 64'd0);
    chk("stall_out_valid", 64'(a_out_valid), 64'd1);
    a_out_ready = 1'b1;
    for (int c = 0; c < 20 && a_acc < 4; c++) begin
      a_in_data = bp_vals[a_acc];
      tick();
    end
    chk("stall_all_accepted", 64'(a_acc), 64'd4);
    drain();

    // Random traffic and backpressure on both instances
    for (int c = 0; c < 300; c++) begin
      a_in_valid = 1'($urandom_range(0, 1)); a_in_mode = 2'($urandom); a_in_data = 16'($urandom);
      a_out_ready = ($urandom_range(0, 3) != 0);
      b_in_valid = 1'($urandom_range(0, 1)); b_in_mode = 2'($urandom); b_in_data = $urandom;
      b_out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    drain();

`ifdef CAST_PIPE_LOSS_CNT_EN
    b_loss_clr = 1'b1;
    tick();
    b_loss_clr = 1'b0;
    chk("cnt_clr", 64'(b_loss_cnt), 64'd0);
    for (int i = 0; i < 3; i++) beat_b("cnt_beat", 2'd1, 32'h01FF_01FF, 16'hFFFF, 2'b11);
    chk("cnt_six", 64'(b_loss_cnt), 64'd6);
    b_acc = 0;
    b_in_valid = 1'b1; b_in_mode = 2'd1; b_in_data = 32'h01FF_01FF;
    for (int c = 0; c < 33000 && b_acc < 32767; c++) tick();
    drain();
    chk("cnt_saturated", 64'(b_loss_cnt), 64'hFFFF);
    b_in_valid = 1'b1;
    tick();
    b_in_valid = 1'b0;
    tick();
    chk("clr_race_valid", 64'(b_out_valid), 64'd1);
    b_loss_clr = 1'b1;
    tick();
    b_loss_clr = 1'b0;
    chk("clr_wins", 64'(b_loss_cnt), 64'd0);
`else
    for (int i = 0; i < 3; i++) beat_b("cnt_beat", 2'd1, 32'h01FF_01FF, 16'hFFFF, 2'b11);
    chk("cnt_disabled", 64'(b_loss_cnt), 64'd0);
`endif

    // Reset with two beats buffered
    a_out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      a_in_valid = 1'b1; a_in_mode = 2'd1; a_in_data = 16'hFFFF;
      tick();
    end
    a_in_valid = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(a_out_valid), 64'd0);
    chk("midrst_out_data", 64'(a_out_data), 64'd0);
    chk("midrst_loss_cnt", 64'(a_loss_cnt), 64'd0);
    a_q.delete();
    b_q.delete();
    a_cnt_m = 16'd0;
    b_cnt_m = 16'd0;
    @(negedge clk);
    rst_n = 1'b1;
    a_out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("no_stale_beat", 64'(a_out_valid), 64'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
